// File: rtl/csa_3var_4b.sv
// Three-operand 4-bit unsigned adder: a carry-save layer, then a ripple-carry adder.
// Two register stages; the result is a full-precision 6-bit sum (maximum 45).
module csa_3var_4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  output logic       out_valid,
  output logic [5:0] sum
);

  logic [3:0] s;
  logic [3:0] cy;
  logic [3:0] s_r;
  logic [3:0] cy_r;
  logic       v1_r;
  logic [5:0] sum_d;
  logic [5:1] rc;

  // One full adder per bit; cy[i] carries weight 2^(i+1).
  always_comb begin
    s  = a ^ b ^ c;
    cy = (a & b) | (a & c) | (b & c);
  end

  // Adds s_r to cy_r shifted left by one. Bit 0 of the shifted carry word is
  // always zero, so bit 0 passes straight through and the chain starts at bit 1.
  always_comb begin
    rc       = '0;
    sum_d    = '0;
    sum_d[0] = s_r[0];
    for (int i = 1; i < 4; i++) begin
      sum_d[i] = s_r[i] ^ cy_r[i-1] ^ rc[i];
      rc[i+1]  = (s_r[i] & cy_r[i-1]) | (rc[i] & (s_r[i] ^ cy_r[i-1]));
    end
    sum_d[4] = cy_r[3] ^ rc[4];
    rc[5]    = cy_r[3] & rc[4];
    sum_d[5] = rc[5];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_r       <= '0;
      cy_r      <= '0;
      v1_r      <= 1'b0;
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        s_r  <= s;
        cy_r <= cy;
      end
      v1_r <= in_valid;
      if (v1_r) begin
        sum <= sum_d;
      end
      out_valid <= v1_r;
    end
  end

endmodule

// File: tb/tb_csa_3var_4b.sv
// Directed bench for csa_3var_4b: each step drives one cycle of inputs,
// then checks the outputs produced by the edge that just passed.
module tb_csa_3var_4b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic       out_valid;
  logic [5:0] sum;

  int ncmp = 0;
  int nerr = 0;

  csa_3var_4b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic cyc(input logic iv, input logic [3:0] ta, input logic [3:0] tb_v,
                     input logic [3:0] tc, input logic eov, input logic [5:0] esum,
                     input string tag);
    in_valid = iv;
    a        = ta;
    b        = tb_v;
    c        = tc;
    @(posedge clk);
    @(negedge clk);
    ncmp++;
    assert (out_valid === eov) else begin
      nerr++;
      $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, eov);
    end
    ncmp++;
    assert (sum === esum) else begin
      nerr++;
      $error("FAIL %s sum: got %0d expected %0d", tag, sum, esum);
    end
  endtask

  initial begin
    logic       pv;
    logic [5:0] ps;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'd15;
    b        = 4'd15;
    c        = 4'd15;
    @(negedge clk);

    cyc(1'b1, 4'd15, 4'd15, 4'd15, 1'b0, 6'd0, "reset0");
    cyc(1'b1, 4'd15, 4'd15, 4'd15, 1'b0, 6'd0, "reset1");
    cyc(1'b1, 4'd15, 4'd15, 4'd15, 1'b0, 6'd0, "reset2");
    rst_n = 1'b1;

    cyc(1'b1, 4'd7,  4'd2,  4'd9,  1'b0, 6'd0,  "first_in");
    cyc(1'b1, 4'd11, 4'd3,  4'd15, 1'b1, 6'd18, "stream0");
    cyc(1'b1, 4'd6,  4'd10, 4'd13, 1'b1, 6'd29, "stream1");
    cyc(1'b1, 4'd11, 4'd5,  4'd8,  1'b1, 6'd29, "stream2");
    cyc(1'b1, 4'd0,  4'd0,  4'd0,  1'b1, 6'd24, "stream3");
    cyc(1'b1, 4'd15, 4'd15, 4'd15, 1'b1, 6'd0,  "ext_zero");
    cyc(1'b1, 4'd15, 4'd0,  4'd0,  1'b1, 6'd45, "ext_max");
    cyc(1'b1, 4'd8,  4'd8,  4'd8,  1'b1, 6'd15, "ext_15");
    cyc(1'b1, 4'd1,  4'd2,  4'd3,  1'b1, 6'd24, "ext_888");

    cyc(1'b0, 4'd9,  4'd9,  4'd9,  1'b1, 6'd6,  "bub_res");
    cyc(1'b0, 4'd9,  4'd9,  4'd9,  1'b0, 6'd6,  "bub_hold0");
    cyc(1'b1, 4'd4,  4'd4,  4'd4,  1'b0, 6'd6,  "bub_hold1");
    cyc(1'b0, 4'd0,  4'd0,  4'd0,  1'b1, 6'd12, "bub_next");

    cyc(1'b1, 4'd10, 4'd10, 4'd10, 1'b0, 6'd12, "mid_accept");
    rst_n = 1'b0;
    cyc(1'b1, 4'd3,  4'd3,  4'd3,  1'b0, 6'd0,  "mid_reset");
    rst_n = 1'b1;
    cyc(1'b1, 4'd1,  4'd1,  4'd1,  1'b0, 6'd0,  "mid_drop");
    cyc(1'b0, 4'd0,  4'd0,  4'd0,  1'b1, 6'd3,  "mid_resume");
    cyc(1'b0, 4'd0,  4'd0,  4'd0,  1'b0, 6'd3,  "mid_idle");

    pv = 1'b0;
    ps = 6'd3;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 16; k++) begin
          cyc(1'b1, 4'(i), 4'(j), 4'(k), pv, ps, "sweep");
          pv = 1'b1;
          ps = 6'(i + j + k);
        end
      end
    end
    cyc(1'b0, 4'd0, 4'd0, 4'd0, pv, ps, "sweep_last");
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, ps, "sweep_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
